// File: rtl/display_image_window.sv
// display_image_window: upscaled view of a double-buffered 8-bit frame memory, with syncs delayed
// to match memory latency, a vsync-synchronised bank swap, colour modes and a frame counter.
module display_image_window #(
    parameter int          HBW        = 12,
    parameter int          VBW        = 11,
    parameter int          IMG_W_LOG2 = 9,
    parameter int          IMG_H_LOG2 = 9,
    parameter int          SCALE_LOG2 = 1,
    parameter int          X0         = 512,
    parameter int          Y0         = 0,
    parameter int          MEM_LAT    = 1,
    parameter logic [7:0]  BG         = 8'd0,
    localparam int         AW         = 1 + IMG_H_LOG2 + IMG_W_LOG2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [HBW-1:0] x,
    input  logic [VBW-1:0] y,
    input  logic           hsync_in,
    input  logic           vsync_in,
    input  logic           de_in,
    input  logic           swap_req,
    input  logic [1:0]     mode,
    output logic [AW-1:0]  addr,
    input  logic [7:0]     data_in,
    output logic           hsync_out,
    output logic           vsync_out,
    output logic           de_out,
    output logic [35:0]    data_out,
    output logic           bank,
    output logic           swap_ack,
    output logic           end_of_frame,
    output logic [15:0]    frame_count
);
    localparam int WIN_W = (1 << IMG_W_LOG2) << SCALE_LOG2;
    localparam int WIN_H = (1 << IMG_H_LOG2) << SCALE_LOG2;

    typedef struct packed {
        logic                  hs;
        logic                  vs;
        logic                  de;
        logic                  win;
        logic [IMG_W_LOG2-1:0] ix;
        logic [IMG_H_LOG2-1:0] iy;
        logic [1:0]            md;
    } stage_t;

    logic [HBW-1:0]        dx;
    logic [VBW-1:0]        dy;
    logic [IMG_W_LOG2-1:0] ix;
    logic [IMG_H_LOG2-1:0] iy;
    logic                  in_win, eof_hit, boundary, vs_q, pending;
    logic [1:0]            active_mode;
    stage_t                pipe [MEM_LAT];
    stage_t                last;
    logic [7:0]            i_val, ix8, iy8, r, g, b;

    assign dx       = x - HBW'(X0);
    assign dy       = y - VBW'(Y0);
    assign ix       = IMG_W_LOG2'(dx >> SCALE_LOG2);
    assign iy       = IMG_H_LOG2'(dy >> SCALE_LOG2);
    assign in_win   = int'(x) >= X0 && int'(x) < X0 + WIN_W && int'(y) >= Y0 && int'(y) < Y0 + WIN_H;
    assign eof_hit  = de_in && x == HBW'(X0 + WIN_W - 1) && y == VBW'(Y0 + WIN_H - 1);
    assign boundary = vsync_in & ~vs_q;
    assign addr     = {bank, iy, ix};
    assign last     = pipe[MEM_LAT-1];

    // MEM_LAT stages line the side info up with data_in; the output register adds the last cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {hsync_in, vsync_in, de_in, in_win, ix, iy, active_mode};
            for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vs_q         <= 1'b0;
            pending      <= 1'b0;
            bank         <= 1'b0;
            swap_ack     <= 1'b0;
            active_mode  <= 2'd0;
            end_of_frame <= 1'b0;
            frame_count  <= 16'd0;
        end else begin
            vs_q     <= vsync_in;
            swap_ack <= boundary && (pending || swap_req);
            if (boundary) begin
                active_mode <= mode;
                bank        <= bank ^ (pending | swap_req);
                pending     <= 1'b0;
            end else begin
                pending <= pending | swap_req;
            end
            end_of_frame <= eof_hit;
            frame_count  <= frame_count + 16'(eof_hit);
        end
    end

    always_comb begin
        i_val = last.win ? data_in : BG;
        ix8   = 8'(last.ix);
        iy8   = 8'(last.iy);
        r     = last.md == 2'd3 ? (last.win ? ix8 : BG) : last.md == 2'd1 ? ~i_val : i_val;
        g     = last.md == 2'd3 ? (last.win ? iy8 : BG) : last.md == 2'd1 ? ~i_val :
                last.md == 2'd2 ? {1'b0, i_val[7:1]} : i_val;
        b     = last.md == 2'd3 ? (last.win ? ix8 ^ iy8 : BG) : last.md == 2'd0 ? i_val : ~i_val;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            de_out    <= 1'b0;
            data_out  <= '0;
        end else begin
            hsync_out <= last.hs;
            vsync_out <= last.vs;
            de_out    <= last.de;
            data_out  <= last.de ? {r, 4'd0, g, 4'd0, b, 4'd0} : '0;
        end
    end
endmodule

// File: tb/tb_display_image_window.sv
// tb_display_image_window: scoreboard bench driving a MEM_LAT=1 and a MEM_LAT=3 viewer side by side.
module tb_display_image_window;
    logic        clock = 1'b0, reset = 1'b0;
    logic [11:0] x = '0;
    logic [10:0] y = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, de_in = 1'b0, swap_req = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [18:0] addr1, addr3;
    logic [7:0]  data1, data3, mem1;
    logic [7:0]  mem3 [3];
    logic        hs1, vs1, de1, hs3, vs3, de3, bank1, bank3, ack1, ack3, eof1, eof3;
    logic [35:0] do1, do3;
    logic [15:0] fc1, fc3;
    int          total = 0, bad = 0;
    logic [38:0] q1[$], q3[$];
    logic [1:0]  m_act = 2'd0;
    logic        vs_prev = 1'b0, pend_m = 1'b0, bank_m = 1'b0, ack_m = 1'b0, eof_m = 1'b0;
    logic [15:0] fc_m = '0;

    always #5 clock = ~clock;

    display_image_window u1 (
        .clock(clock), .reset(reset), .x(x), .y(y), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .de_in(de_in), .swap_req(swap_req), .mode(mode), .addr(addr1), .data_in(data1),
        .hsync_out(hs1), .vsync_out(vs1), .de_out(de1), .data_out(do1), .bank(bank1),
        .swap_ack(ack1), .end_of_frame(eof1), .frame_count(fc1)
    );

    display_image_window #(.MEM_LAT(3)) u3 (
        .clock(clock), .reset(reset), .x(x), .y(y), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .de_in(de_in), .swap_req(swap_req), .mode(mode), .addr(addr3), .data_in(data3),
        .hsync_out(hs3), .vsync_out(vs3), .de_out(de3), .data_out(do3), .bank(bank3),
        .swap_ack(ack3), .end_of_frame(eof3), .frame_count(fc3)
    );

    // frame memory stand-in: each location holds the low address byte
    always @(posedge clock) begin
        mem1    <= addr1[7:0];
        mem3[0] <= addr3[7:0];
        mem3[1] <= mem3[0];
        mem3[2] <= mem3[1];
    end
    assign data1 = mem1;
    assign data3 = mem3[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic logic [38:0] exp_px(input int xx, input int yy, input logic hs, input logic vs,
                                           input logic d, input logic [1:0] m);
        bit win;
        int iv, ix8, iy8, r, g, b;
        win = xx >= 512 && xx < 1536 && yy < 1024;
        ix8 = win ? ((xx - 512) / 2) % 256 : 0;
        iy8 = (yy / 2) % 256;
        iv  = win ? ix8 : 0;
        if (m == 2'd3) begin r = win ? ix8 : 0; g = win ? iy8 : 0; b = win ? (ix8 ^ iy8) : 0; end
        else if (m == 2'd2) begin r = iv; g = iv / 2; b = 255 - iv; end
        else if (m == 2'd1) begin r = 255 - iv; g = r; b = r; end
        else begin r = iv; g = iv; b = iv; end
        if (!d) begin r = 0; g = 0; b = 0; end
        return {hs, vs, d, r[7:0], 4'h0, g[7:0], 4'h0, b[7:0], 4'h0};
    endfunction

    // one pixel clock: called just after a rising edge, returns just after the next one
    task automatic cyc(input int xx, input int yy, input logic d);
        logic [38:0] e;
        logic        bnd;
        x = 12'(xx);
        y = 11'(yy);
        de_in = d;
        e = exp_px(xx, yy, hsync_in, vsync_in, d, m_act);
        q1.push_back(e);
        q3.push_back(e);
        #1;
        if (xx >= 512 && xx < 1536 && yy < 1024) begin
            chk("addr1", addr1, {bank_m, 9'(yy / 2), 9'((xx - 512) / 2)});
            chk("addr3", addr3, {bank_m, 9'(yy / 2), 9'((xx - 512) / 2)});
        end
        @(negedge clock);
        if (q1.size() > 2) chk("pix1", {hs1, vs1, de1, do1}, q1.pop_front());
        if (q3.size() > 4) chk("pix3", {hs3, vs3, de3, do3}, q3.pop_front());
        chk("bank1", bank1, bank_m);
        chk("bank3", bank3, bank_m);
        chk("ack1", ack1, ack_m);
        chk("ack3", ack3, ack_m);
        chk("eof1", eof1, eof_m);
        chk("eof3", eof3, eof_m);
        chk("fc1", fc1, fc_m);
        chk("fc3", fc3, fc_m);
        bnd   = vsync_in && !vs_prev;
        ack_m = bnd && (pend_m || swap_req);
        if (bnd) begin
            if (pend_m || swap_req) bank_m = !bank_m;
            pend_m = 1'b0;
            m_act  = mode;
        end else begin
            pend_m = pend_m || swap_req;
        end
        eof_m = d && xx == 1535 && yy == 1023;
        if (eof_m) fc_m = fc_m + 16'd1;
        vs_prev = vsync_in;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_u1"}, {hs1, vs1, de1, do1, bank1, ack1, eof1, fc1}, '0);
        chk({tag, "_u3"}, {hs3, vs3, de3, do3, bank3, ack3, eof3, fc3}, '0);
    endtask

    task automatic release_reset();
        reset = 1'b1;
        m_act = 2'd0; vs_prev = 1'b0; pend_m = 1'b0; bank_m = 1'b0; ack_m = 1'b0; eof_m = 1'b0;
        fc_m = '0;
        q1.delete();
        q3.delete();
        repeat (2) q1.push_back('0);
        repeat (4) q3.push_back('0);
    endtask

    task automatic vpulse();
        vsync_in = 1'b1;
        cyc(0, 1030, 0);
        vsync_in = 1'b0;
        cyc(1, 1030, 0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk_zero("reset_state");
        release_reset();
        hsync_in = 1'b1; cyc(0, 0, 0); cyc(1, 0, 0); hsync_in = 1'b0;
        cyc(511, 0, 1); cyc(512, 0, 1); cyc(1535, 0, 1); cyc(1536, 0, 1); cyc(1600, 0, 0);
        x = 12'd514; y = 11'd6; de_in = 1'b1;
        #1 chk("addr_514_6", addr1, {1'b0, 9'd3, 9'd1});
        cyc(514, 6, 1); cyc(515, 6, 1);
        chk("pix_514_6", {de1, do1}, {1'b1, 8'd1, 4'd0, 8'd1, 4'd0, 8'd1, 4'd0});
        for (int i = 0; i < 16; i++) cyc(512 + i * 61, 100 + i * 53, 1'(i % 3 != 0));
        vpulse();
        // swap request mid-frame takes effect only at the next vsync rise
        swap_req = 1'b1; cyc(600, 10, 1); swap_req = 1'b0;
        repeat (3) cyc(601, 10, 1);
        chk("bank_held", bank1, 1'b0);
        vsync_in = 1'b1; cyc(0, 1030, 0);
        chk("bank_swap1", bank1, 1'b1);
        chk("ack_pulse", ack1, 1'b1);
        vsync_in = 1'b0; cyc(1, 1030, 0);
        chk("ack_single", ack1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            swap_req = 1'b1; cyc(700 + i, 20, 1); swap_req = 1'b0; cyc(710 + i, 20, 1);
        end
        vpulse();
        vpulse();
        chk("bank_one_toggle", bank3, 1'b0);
        swap_req = 1'b1; vsync_in = 1'b1; cyc(0, 1030, 0);
        swap_req = 1'b0; vsync_in = 1'b0;
        chk("bank_coincident", bank1, 1'b1);
        cyc(1, 1030, 0);
        // mode is picked up only at the frame boundary
        mode = 2'd2;
        cyc(768, 20, 1); cyc(769, 20, 1); cyc(770, 20, 1);
        chk("mode_held_grey", do1, {8'h80, 4'd0, 8'h80, 4'd0, 8'h80, 4'd0});
        vpulse();
        cyc(768, 20, 1); cyc(769, 20, 1); cyc(770, 20, 1);
        chk("false_colour", do1, {8'h80, 4'd0, 8'h40, 4'd0, 8'h7F, 4'd0});
        mode = 2'd3; vpulse();
        for (int i = 0; i < 6; i++) cyc(500 + i * 5, 40 + i * 7, 1);
        mode = 2'd1; vpulse();
        for (int i = 0; i < 6; i++) cyc(508 + i * 3, 900 + i, 1);
        mode = 2'd0; vpulse();
        cyc(1534, 1023, 1); cyc(1535, 1023, 1);
        chk("eof_high", eof1, 1'b1);
        chk("fc_first", fc1, 16'd1);
        cyc(1536, 1023, 1);
        chk("eof_low", eof1, 1'b0);
        for (int i = 0; i < 65535; i++) cyc(1535, 1023, 1);
        chk("fc_wrap", fc1, 16'd0);
        cyc(0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(700 + i, 50, 1);
        #2 reset = 1'b0;
        #1 chk_zero("async_reset");
        @(posedge clock);
        #1;
        release_reset();
        for (int i = 0; i < 6; i++) cyc(520 + i, 60, 1);
        repeat (5) cyc(0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
